// File: rtl/barrier_pkg.sv
// Shared lane state encoding, geometry defaults and lane-index width helper
// for the barrier lane manager and its per-lane FSM.
package barrier_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_SCROLL = 2'd1,
    LANE_ZONE   = 2'd2
  } lane_state_t;

  localparam int DEF_NUM_LANES  = 3;
  localparam int DEF_SPEED      = 4;
  localparam int DEF_LANE_X0    = 192;
  localparam int DEF_LANE_PITCH = 128;
  localparam int DEF_BARRIER_W  = 64;
  localparam int DEF_BARRIER_H  = 32;
  localparam int DEF_Y_START    = 0;
  localparam int DEF_HIT_Y_TOP  = 400;
  localparam int DEF_HIT_Y_BOT  = 440;
  localparam int DEF_Y_END      = 480;
  localparam logic [23:0] DEF_BARRIER_RGB = 24'hC0E0FF;

  // Lane index width: value 0 is reserved for "no lane".
  function automatic int lane_w(input int num_lanes);
    return $clog2(num_lanes + 1);
  endfunction

endpackage

// File: rtl/barrier_lane.sv
// One barrier lane: IDLE/SCROLL/ZONE FSM, saturating top-edge y and pixel rectangle test.
// Hit/cleared pulses are registered (one cycle after the frame tick); spawn is accepted only while IDLE.
module barrier_lane
  import barrier_pkg::*;
#(
  parameter int LANE_IDX   = 1,
  parameter int SPEED      = DEF_SPEED,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int BARRIER_W  = DEF_BARRIER_W,
  parameter int BARRIER_H  = DEF_BARRIER_H,
  parameter int Y_START    = DEF_Y_START,
  parameter int HIT_Y_TOP  = DEF_HIT_Y_TOP,
  parameter int HIT_Y_BOT  = DEF_HIT_Y_BOT,
  parameter int Y_END      = DEF_Y_END
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_spawn,
  input  logic        i_tick,
  input  logic        i_penguin_here,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic        o_idle,
  output logic        o_hit,
  output logic        o_cleared,
  output logic        o_pixel
);

  localparam logic [16:0] X0  = 17'(LANE_X0 + (LANE_IDX - 1) * LANE_PITCH);
  localparam logic [16:0] W17 = 17'(BARRIER_W);
  localparam logic [16:0] H17 = 17'(BARRIER_H);

  lane_state_t state, state_nxt;
  logic [15:0] y, y_nxt;
  logic        hit_nxt, clr_nxt;

  logic [16:0] y_sum;
  logic [15:0] y_adv;
  logic [16:0] bot_adv;

  // 17-bit sums keep the carry so the advance saturates instead of wrapping.
  assign y_sum   = {1'b0, y} + 17'(SPEED);
  assign y_adv   = y_sum[16] ? 16'hFFFF : y_sum[15:0];
  assign bot_adv = {1'b0, y_adv} + H17;

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    hit_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      LANE_IDLE: begin
        if (i_spawn) begin
          state_nxt = LANE_SCROLL;
          y_nxt     = 16'(Y_START);
        end
      end
      LANE_SCROLL: begin
        if (i_tick) begin
          y_nxt = y_adv;
          if (bot_adv >= 17'(HIT_Y_TOP)) state_nxt = LANE_ZONE;
        end
      end
      LANE_ZONE: begin
        if (i_tick) begin
          y_nxt = y_adv;
          // Once the bottom edge is past HIT_Y_BOT the barrier can no longer hit.
          if (i_penguin_here && (bot_adv <= 17'(HIT_Y_BOT))) begin
            hit_nxt   = 1'b1;
            state_nxt = LANE_IDLE;
          end else if (y_adv >= 16'(Y_END)) begin
            clr_nxt   = 1'b1;
            state_nxt = LANE_IDLE;
          end
        end
      end
      default: state_nxt = LANE_IDLE;
    endcase
    if (i_clear) begin
      state_nxt = LANE_IDLE;
      y_nxt     = 16'(Y_START);
      hit_nxt   = 1'b0;
      clr_nxt   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= LANE_IDLE;
      y         <= 16'(Y_START);
      o_hit     <= 1'b0;
      o_cleared <= 1'b0;
    end else begin
      state     <= state_nxt;
      y         <= y_nxt;
      o_hit     <= hit_nxt;
      o_cleared <= clr_nxt;
    end
  end

  logic [16:0] px, py, ytop;
  assign px   = {1'b0, i_x};
  assign py   = {1'b0, i_y};
  assign ytop = {1'b0, y};

  assign o_idle  = (state == LANE_IDLE);
  assign o_pixel = (state != LANE_IDLE) &&
                   (px >= X0) && (px < X0 + W17) &&
                   (py >= ytop) && (py < ytop + H17);

endmodule

// File: rtl/barrier_lane_manager.sv
// Barrier lanes top: v_sync synchroniser/edge detect, spawn routing, hit OR-reduce and pixel colour mux.
// Frame tick lands 2 cycles after v_sync rises; spawn_ready is combinational from registered lane state.
module barrier_lane_manager
  import barrier_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int SPEED      = DEF_SPEED,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int BARRIER_W  = DEF_BARRIER_W,
  parameter int BARRIER_H  = DEF_BARRIER_H,
  parameter int Y_START    = DEF_Y_START,
  parameter int HIT_Y_TOP  = DEF_HIT_Y_TOP,
  parameter int HIT_Y_BOT  = DEF_HIT_Y_BOT,
  parameter int Y_END      = DEF_Y_END,
  parameter logic [23:0] BARRIER_RGB = DEF_BARRIER_RGB,
  localparam int LW        = lane_w(NUM_LANES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [15:0]          i_x,
  input  logic [15:0]          i_y,
  input  logic                 i_v_sync,
  input  logic                 i_spawn_valid,
  input  logic [LW-1:0]        i_spawn_lane,
  output logic                 o_spawn_ready,
  input  logic [LW-1:0]        i_current_lane,
  input  logic                 i_in_air,
  input  logic                 i_clear_all,
  output logic [7:0]           o_red,
  output logic [7:0]           o_green,
  output logic [7:0]           o_blue,
  output logic                 o_sprite_hit,
  output logic                 o_penguin_hit,
  output logic [NUM_LANES-1:0] o_cleared
);

  logic v_meta, v_sync2, v_prev, tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_meta  <= 1'b0;
      v_sync2 <= 1'b0;
      v_prev  <= 1'b0;
    end else begin
      v_meta  <= i_v_sync;
      v_sync2 <= v_meta;
      v_prev  <= v_sync2;
    end
  end

  assign tick = v_sync2 & ~v_prev;

  logic [NUM_LANES-1:0] lane_sel, lane_idle, spawn_go, penguin_here, lane_hit, lane_pix;

  // Lane k+1 maps to bit k; index 0 and out-of-range values select nothing.
  always_comb begin
    lane_sel     = '0;
    penguin_here = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_sel[k]     = (i_spawn_lane == LW'(k + 1));
      penguin_here[k] = (i_current_lane == LW'(k + 1)) && !i_in_air;
    end
  end

  assign o_spawn_ready = |(lane_sel & lane_idle);
  assign spawn_go      = (i_spawn_valid && o_spawn_ready && !i_clear_all) ? lane_sel : '0;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    barrier_lane #(
      .LANE_IDX   (k + 1),
      .SPEED      (SPEED),
      .LANE_X0    (LANE_X0),
      .LANE_PITCH (LANE_PITCH),
      .BARRIER_W  (BARRIER_W),
      .BARRIER_H  (BARRIER_H),
      .Y_START    (Y_START),
      .HIT_Y_TOP  (HIT_Y_TOP),
      .HIT_Y_BOT  (HIT_Y_BOT),
      .Y_END      (Y_END)
    ) u_lane (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_clear        (i_clear_all),
      .i_spawn        (spawn_go[k]),
      .i_tick         (tick),
      .i_penguin_here (penguin_here[k]),
      .i_x            (i_x),
      .i_y            (i_y),
      .o_idle         (lane_idle[k]),
      .o_hit          (lane_hit[k]),
      .o_cleared      (o_cleared[k]),
      .o_pixel        (lane_pix[k])
    );
  end

  assign o_penguin_hit = |lane_hit;
  assign o_sprite_hit  = |lane_pix;
  assign {o_red, o_green, o_blue} = o_sprite_hit ? BARRIER_RGB : 24'h0;

endmodule

// File: tb/tb_barrier_lane_manager.sv
// Randomised and directed bench for barrier_lane_manager against an age-based lane model.
module tb_barrier_lane_manager;

  localparam int NL = 3, SPEED = 4, X0 = 192, PITCH = 128, BW = 64, BH = 32;
  localparam int TOP = 400, BOT = 440, YEND = 480;
  localparam logic [23:0] RGB = 24'hC0E0FF;

  logic        clk = 1'b0, rst = 1'b1, v_sync = 1'b0, spawn_valid = 1'b0;
  logic        in_air = 1'b0, clear_all = 1'b0;
  logic [15:0] px = 16'd0, py = 16'd0;
  logic [1:0]  spawn_lane = 2'd0, cur_lane = 2'd0;
  logic        spawn_ready, sprite_hit, penguin_hit;
  logic [7:0]  red, green, blue;
  logic [2:0]  cleared;

  int checks = 0, failures = 0;
  bit act[1:3];
  int age[1:3];
  int m_hit = 0, obs_hit = 0;
  int m_clr[1:3];
  int obs_clr[1:3];

  always #5 clk = ~clk;

  barrier_lane_manager #(.NUM_LANES(NL), .SPEED(SPEED)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(px), .i_y(py), .i_v_sync(v_sync),
    .i_spawn_valid(spawn_valid), .i_spawn_lane(spawn_lane), .o_spawn_ready(spawn_ready),
    .i_current_lane(cur_lane), .i_in_air(in_air), .i_clear_all(clear_all),
    .o_red(red), .o_green(green), .o_blue(blue), .o_sprite_hit(sprite_hit),
    .o_penguin_hit(penguin_hit), .o_cleared(cleared)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (penguin_hit === 1'b1) obs_hit++;
      for (int k = 1; k <= NL; k++)
        if (cleared[k-1] === 1'b1) obs_clr[k]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int model_y(input int l);
    int y;
    y = SPEED * age[l];
    return (y > 65535) ? 65535 : y;
  endfunction

  function automatic bit sprite_exp(input int x, input int y);
    bit e;
    int x0, yt;
    e = 1'b0;
    for (int k = 1; k <= NL; k++) begin
      x0 = X0 + (k - 1) * PITCH;
      yt = model_y(k);
      if (act[k] && x >= x0 && x < x0 + BW && y >= yt && y < yt + BH) e = 1'b1;
    end
    return e;
  endfunction

  // One frame: barrier moves SPEED px; it may hit only if it was already in the hit zone.
  task automatic model_tick();
    int yo, yn;
    bit zone;
    for (int k = 1; k <= NL; k++) begin
      if (act[k]) begin
        yo   = model_y(k);
        yn   = (yo + SPEED > 65535) ? 65535 : yo + SPEED;
        zone = (yo + BH >= TOP);
        if (zone && int'(cur_lane) == k && !in_air && yn + BH <= BOT) begin
          m_hit++;
          act[k] = 1'b0;
        end else if (zone && yn >= YEND) begin
          m_clr[k]++;
          act[k] = 1'b0;
        end else begin
          age[k]++;
        end
      end
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_hits"}, obs_hit, m_hit);
    for (int k = 1; k <= NL; k++)
      check_eq($sformatf("%s_cleared%0d", tag, k), obs_clr[k], m_clr[k]);
  endtask

  task automatic frame();
    @(negedge clk);
    v_sync = 1'b1;
    cyc(4);
    v_sync = 1'b0;
    model_tick();
    cyc(4);
    #2;
    check_counts("frame");
  endtask

  task automatic spawn(input int l);
    bit exp;
    int lv;
    @(negedge clk);
    spawn_lane  = 2'(l);
    spawn_valid = 1'b1;
    lv  = int'(spawn_lane);
    exp = (lv >= 1 && lv <= NL) ? !act[lv] : 1'b0;
    #1;
    check_eq($sformatf("spawn_ready_l%0d", l), spawn_ready, exp);
    @(posedge clk);
    if (exp) begin
      act[lv] = 1'b1;
      age[lv] = 0;
    end
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  task automatic pix_at(input string tag, input int x, input int y, input bit exp);
    @(negedge clk);
    px = 16'(x);
    py = 16'(y);
    #1;
    check_eq({tag, "_sprite"}, sprite_hit, exp);
    check_eq({tag, "_rgb"}, {red, green, blue}, exp ? RGB : 24'h0);
  endtask

  task automatic pix_check();
    int l, x, y;
    l = $urandom_range(1, NL);
    if ($urandom_range(0, 1) == 1) begin
      x = X0 + (l - 1) * PITCH + $urandom_range(0, BW + 7) - 4;
      y = model_y(l) + $urandom_range(0, BH + 9) - 5;
      if (y < 0) y = 0;
    end else begin
      x = $urandom_range(150, 600);
      y = $urandom_range(0, 520);
    end
    pix_at("pix", x, y, sprite_exp(x, y));
  endtask

  // Reset or clear_all with a competing spawn: every lane must go idle silently.
  task automatic do_clear(input bit use_rst);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else clear_all = 1'b1;
    spawn_valid = 1'b1;
    spawn_lane  = 2'($urandom_range(1, NL));
    @(negedge clk);
    rst = 1'b0;
    clear_all = 1'b0;
    spawn_valid = 1'b0;
    for (int k = 1; k <= NL; k++) act[k] = 1'b0;
    #1;
    check_eq("clear_ready", spawn_ready, 1'b1);
    check_eq("clear_red", red, 8'h0);
    cyc(3);
    #2;
    check_counts("clear");
  endtask

  initial begin
    int h0, c0, r;
    for (int k = 1; k <= NL; k++) begin
      act[k] = 1'b0; age[k] = 0; m_clr[k] = 0; obs_clr[k] = 0;
    end
    spawn_lane = 2'd1;
    cyc(3);
    rst = 1'b0;
    #1;
    check_eq("rst_penguin_hit", penguin_hit, 1'b0);
    check_eq("rst_cleared", cleared, 3'b000);
    check_eq("rst_sprite", sprite_hit, 1'b0);
    check_eq("rst_red", red, 8'h0);
    check_eq("rst_ready_l1", spawn_ready, 1'b1);
    spawn_lane = 2'd0;
    #1;
    check_eq("rst_ready_l0", spawn_ready, 1'b0);

    // Lane 2 runs the full screen with no penguin.
    c0 = obs_clr[2]; h0 = obs_hit;
    spawn(2);
    repeat (119) frame();
    check_eq("clr_before_end", obs_clr[2] - c0, 0);
    frame();
    check_eq("clr_at_end", obs_clr[2] - c0, 1);
    check_eq("clr_no_hit", obs_hit - h0, 0);

    // Penguin standing in lane 1.
    cur_lane = 2'd1; in_air = 1'b0; h0 = obs_hit;
    spawn(1);
    repeat (92) frame();
    check_eq("hit_zone_entry", obs_hit - h0, 0);
    pix_at("zone_pix", 200, 372, 1'b1);
    frame();
    check_eq("hit_pulse", obs_hit - h0, 1);
    pix_at("hit_gone_pix", 200, 372, 1'b0);
    repeat (10) frame();
    check_eq("hit_single", obs_hit - h0, 1);

    // Penguin airborne throughout the zone.
    in_air = 1'b1; h0 = obs_hit; c0 = obs_clr[1];
    spawn(1);
    repeat (120) frame();
    check_eq("air_no_hit", obs_hit - h0, 0);
    check_eq("air_cleared", obs_clr[1] - c0, 1);
    cur_lane = 2'd0; in_air = 1'b0;

    // Busy-lane and out-of-range spawns, then clear/reset with lanes in the zone.
    spawn(1);
    spawn(3);
    spawn(1);
    spawn(4);
    repeat (95) frame();
    pix_at("zone2_pix", 200, 384, 1'b1);
    do_clear(1'b0);
    pix_at("after_clear_pix", 200, 384, 1'b0);
    spawn(1);
    spawn(2);
    repeat (95) frame();
    do_clear(1'b1);
    pix_at("after_rst_pix", 200, 384, 1'b0);

    for (int i = 0; i < 1200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) spawn($urandom_range(0, 4));
      if (r == 99) do_clear($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cur_lane = 2'($urandom_range(0, 3));
        in_air   = ($urandom_range(0, 3) == 0);
      end
      frame();
      pix_check();
      pix_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrier_lane_manager.md
BARRIER_LANE_MANAGER -- requirements
Module: barrier_lane_manager

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, number of independent barrier lanes (1..7).
REQ-002 SHALL have parameter SPEED, default 4, pixels advanced per frame.
REQ-003 SHALL have parameters LANE_X0 = 192, LANE_PITCH = 128, BARRIER_W = 64, BARRIER_H = 32: lane-k left edge = LANE_X0 + (k-1)*LANE_PITCH.
REQ-004 SHALL have parameters Y_START = 0, HIT_Y_TOP = 400, HIT_Y_BOT = 440, Y_END = 480, BARRIER_RGB = 24'hC0E0FF.
REQ-005 i_clk  in  1  system clock; the only clock.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_x, i_y  in  16 each  current pixel coordinate.
REQ-008 i_v_sync  in  1  frame sync from the display timing block; asynchronous to frame content, sampled on i_clk.
REQ-009 i_spawn_valid  in  1; i_spawn_lane  in  LW = $clog2(NUM_LANES+1)  spawn request; lane 0 means none.
REQ-010 o_spawn_ready  out  1  target lane can accept a spawn.
REQ-011 i_current_lane  in  LW  penguin lane (0 = none); i_in_air  in  1  penguin airborne.
REQ-012 i_clear_all  in  1  synchronous removal of all barriers (game over / restart).
REQ-013 o_red, o_green, o_blue  out  8 each; o_sprite_hit  out  1  barrier pixel present.
REQ-014 o_penguin_hit  out  1  one-cycle life-loss pulse; o_cleared  out  NUM_LANES  per-lane one-cycle pulse, barrier passed unhit.

Function
REQ-015 Each lane SHALL run its own FSM: IDLE -> SCROLL -> ZONE -> IDLE, holding a 16-bit top-edge register y.
REQ-016 A frame tick SHALL be a one-cycle pulse, one cycle after i_v_sync is sampled high following a low sample (2-flop sync plus edge detect).
REQ-017 o_spawn_ready SHALL be 1 iff 1 <= i_spawn_lane <= NUM_LANES and that lane is IDLE.
REQ-018 Spawn SHALL occur when i_spawn_valid and o_spawn_ready are both 1 on a rising edge: lane -> SCROLL, y = Y_START, next cycle; other lanes unaffected.
REQ-019 Out-of-range i_spawn_lane SHALL give o_spawn_ready = 0 and be ignored.
REQ-020 On each frame tick every non-IDLE lane SHALL add SPEED to y in 16-bit unsigned arithmetic, saturating at 16'hFFFF.
REQ-021 SCROLL -> ZONE SHALL occur on the tick where updated y + BARRIER_H >= HIT_Y_TOP.
REQ-022 In ZONE, on a tick where i_current_lane equals the lane index and i_in_air = 0 SHALL: pulse o_penguin_hit one cycle, lane -> IDLE (barrier vanishes).
REQ-023 Each barrier SHALL cause at most one o_penguin_hit.
REQ-024 In ZONE, if updated y >= Y_END with no hit, SHALL pulse o_cleared[lane-1] one cycle and go IDLE.
REQ-025 Lane in ZONE whose bottom passes HIT_Y_BOT SHALL stay ZONE but be collision-exempt until cleared.
REQ-026 Hit takes priority over clear in the same tick.
REQ-027 Spawn into a lane in the same cycle it goes IDLE SHALL NOT be accepted (ready reflects registered state).
REQ-028 i_clear_all SHALL force all lanes IDLE next cycle with no hit/cleared pulses; it overrides a simultaneous spawn.
REQ-029 o_sprite_hit SHALL be combinational from registered state: 1 iff some non-IDLE lane satisfies x0 <= i_x < x0+BARRIER_W and y <= i_y < y+BARRIER_H.
REQ-030 RGB SHALL equal BARRIER_RGB when o_sprite_hit = 1, else 0 (no latched colour).
REQ-031 The design SHALL contain no latches; every output fully assigned every cycle.

Reset
REQ-032 On i_rst = 1 at a rising edge: all lanes IDLE, y = Y_START, sync flops 0, o_penguin_hit = 0, o_cleared = 0; RGB and o_sprite_hit = 0 thereafter until a spawn.
REQ-033 Reset mid-scroll or mid-ZONE SHALL discard the barrier without any pulse.

Structure
REQ-034 Lane-state enum, LW function, and geometry defaults SHALL live in package barrier_pkg.
REQ-035 One sub-module barrier_lane (one FSM + y register + rectangle test) SHALL be instantiated NUM_LANES times via generate; the top holds sync, spawn routing, hit OR-reduce and pixel mux.

Verification
REQ-036 Spawn lane 2, no penguin: y reaches 480 after 120 ticks -> o_cleared = 3'b010 for one cycle, o_penguin_hit never 1.
REQ-037 Spawn lane 1, i_current_lane = 1, i_in_air = 0: on tick when y = 368 (368+32 >= 400, ZONE) and next tick -> single o_penguin_hit pulse, lane IDLE, o_sprite_hit = 0 at (200,372).
REQ-038 Same as 037 with i_in_air = 1 throughout ZONE -> no hit, o_cleared[0] pulse.
REQ-039 Spawn lanes 1 and 3 same cycle-sequence; spawn lane 1 again while active -> o_spawn_ready = 0, request ignored; i_spawn_lane = 4 -> ready 0.
REQ-040 Assert i_rst and, separately, i_clear_all with two lanes in ZONE -> all IDLE next cycle, no pulses, o_red = 0.
